rr_lock_arbiter: RTL and testbench
==================================

RR_LOCK_ARBITER -- requirements
Module: rr_lock_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16, giving the maximum consecutive cycles one grant may be held; legal range 2..256.
REQ-002 The block SHALL have port clk, input, 1, the clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-004 The block SHALL have port req, input, 4, one request line per requester 0..3, level-sensitive.
REQ-005 The block SHALL have port done, input, 4, per-requester release strobe; only the bit of the current owner is honoured.
REQ-006 The block SHALL have port grant, output, 4, registered grant, one-hot or zero.
REQ-007 The block SHALL have port grant_id, output, 2, registered index of the current owner; 0 when no grant is active.
REQ-008 The block SHALL have port busy, output, 1, registered; high exactly when grant is nonzero.
REQ-009 The block SHALL have port timeout, output, 1, registered; single-cycle pulse on a forced release.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (grant=0) and GRANT (grant holds one bit).
REQ-011 In IDLE with req nonzero, the block SHALL select the first asserted request in the order last_id+1, last_id+2, last_id+3, last_id (mod 4), where last_id is the most recent owner.
REQ-012 The selected grant, grant_id and busy SHALL appear on the edge after req is sampled, giving one-cycle request-to-grant latency; the FSM SHALL enter GRANT and clear hold_cnt to 0 on that edge.
REQ-013 In IDLE with req=0, the block SHALL stay in IDLE with all outputs 0.
REQ-014 In GRANT, on each edge, the first matching rule below SHALL apply: (a) done[id]=1 or req[id]=0: release; (b) hold_cnt=MAX_HOLD-1: release and assert timeout; (c) otherwise increment hold_cnt and keep grant.
REQ-015 On release, the block SHALL set grant, grant_id and busy to 0, set last_id to the releasing id, and return to IDLE.
REQ-016 A grant SHALL therefore remain high for at most MAX_HOLD consecutive cycles.
REQ-017 Between two grants there SHALL be at least one IDLE cycle with grant=0, including when the same requester regains the grant.
REQ-018 When done[id] and the hold limit occur in the same cycle, the block SHALL release without asserting timeout.
REQ-019 done bits of non-owning requesters SHALL be ignored in every state.
REQ-020 Changes on req for non-owners during GRANT SHALL NOT affect the current grant; they are evaluated only in IDLE.
REQ-021 hold_cnt SHALL be 8 bits wide and SHALL never wrap: it saturates by release at MAX_HOLD-1.
REQ-022 timeout SHALL be high only in the first IDLE cycle after a forced release, and 0 otherwise.
REQ-023 grant SHALL never have more than one bit set.

Reset
REQ-024 While rst is high, the block SHALL force, asynchronously: grant=0, grant_id=0, busy=0, timeout=0, hold_cnt=0, FSM=IDLE, last_id=3, so requester 0 has top priority after reset.
REQ-025 Assertion of rst during GRANT SHALL drop grant immediately, without waiting for a clock edge, and without a timeout pulse.
REQ-026 After rst deasserts, the first arbitration SHALL occur on the first rising edge with req nonzero.

Verification
REQ-027 After reset, req=0001 held, done=0 -> grant=0001, grant_id=0, busy=1 one cycle later.
REQ-028 req=1111 held, done[id] pulsed on each grant's 2nd cycle -> owners 0,1,2,3,0, each grant 2 cycles, one zero cycle between grants.
REQ-029 MAX_HOLD=4, req=0100 held, done=0 -> grant=0100 for exactly 4 cycles, then grant=0 with timeout=1 for 1 cycle, then grant=0100 again.
REQ-030 Owner 1 drops req[1] in the 3rd grant cycle while req=1001 remain -> grant=0 on the next edge, then grant=1000 (id 3 precedes 0 after last_id=1).
REQ-031 Owner 2 holds the grant while done=1011 is pulsed -> grant stays 0100; then done[2] and the hold limit coincide -> release with timeout=0.
REQ-032 rst asserted mid-grant with req=0010 -> grant=0 immediately; after release, req=1010 -> grant=0010 first (last_id=3 restored).

Source files
------------

// File: rtl/rr_lock_arbiter.sv
// Four-requester round-robin arbiter with lock-until-done grants and a hold-time limit.
// A grant lasts until the owner signals done, drops its request, or holds it for MAX_HOLD cycles.
module rr_lock_arbiter #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [3:0] done,
   output logic [3:0] grant,
   output logic [1:0] grant_id,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   state_t     state_r;
   state_t     state_nxt_s;
   logic [7:0] hold_cnt_r;
   logic [7:0] hold_cnt_nxt_s;
   logic [1:0] last_id_r;
   logic [1:0] last_id_nxt_s;
   logic [1:0] cand_s;
   logic [1:0] sel_id_s;
   logic       sel_valid_s;
   logic       release_s;
   logic       forced_s;
   logic [3:0] grant_nxt_s;
   logic [1:0] grant_id_nxt_s;
   logic       busy_nxt_s;
   logic       timeout_nxt_s;

   // Rotating-priority pick: walk offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      cand_s      = 2'd0;
      sel_id_s    = 2'd0;
      sel_valid_s = |req;
      for (int i = 4; i >= 1; i--) begin
         cand_s   = last_id_r + 2'(i);
         sel_id_s = req[cand_s] ? cand_s : sel_id_s;
      end
   end

   // Next-state logic: arbitration in IDLE, release rules in GRANT.
   always_comb begin
      state_nxt_s    = state_r;
      hold_cnt_nxt_s = hold_cnt_r;
      last_id_nxt_s  = last_id_r;
      release_s      = 1'b0;
      forced_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (sel_valid_s) begin
               state_nxt_s    = GRANT;
               hold_cnt_nxt_s = 8'd0;
            end else begin
               state_nxt_s    = IDLE;
            end
         end
         GRANT: begin
            // A done at the hold limit is a normal release, so it is tested first.
            if (done[grant_id] || !req[grant_id]) begin
               release_s = 1'b1;
            end else if (hold_cnt_r == HOLD_LAST) begin
               release_s = 1'b1;
               forced_s  = 1'b1;
            end else begin
               hold_cnt_nxt_s = hold_cnt_r + 8'd1;
            end
            if (release_s) begin
               state_nxt_s    = IDLE;
               last_id_nxt_s  = grant_id;
               hold_cnt_nxt_s = 8'd0;
            end else begin
               state_nxt_s    = GRANT;
            end
         end
         default: begin
            state_nxt_s    = IDLE;
            hold_cnt_nxt_s = 8'd0;
         end
      endcase
   end

   // Output decode for the values that are registered on the next edge.
   always_comb begin
      grant_nxt_s    = 4'd0;
      grant_id_nxt_s = 2'd0;
      busy_nxt_s     = 1'b0;
      timeout_nxt_s  = forced_s;
      if (state_nxt_s == GRANT) begin
         if (state_r == IDLE) begin
            grant_id_nxt_s = sel_id_s;
         end else begin
            grant_id_nxt_s = grant_id;
         end
         grant_nxt_s = 4'b0001 << grant_id_nxt_s;
         busy_nxt_s  = 1'b1;
      end else begin
         grant_nxt_s    = 4'd0;
         grant_id_nxt_s = 2'd0;
         busy_nxt_s     = 1'b0;
      end
   end

   // State and output registers; reset leaves requester 0 with top priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         hold_cnt_r <= 8'd0;
         last_id_r  <= 2'd3;
         grant      <= 4'd0;
         grant_id   <= 2'd0;
         busy       <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         hold_cnt_r <= hold_cnt_nxt_s;
         last_id_r  <= last_id_nxt_s;
         grant      <= grant_nxt_s;
         grant_id   <= grant_id_nxt_s;
         busy       <= busy_nxt_s;
         timeout    <= timeout_nxt_s;
      end
   end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter with MAX_HOLD=4; expected outputs are hand-computed.
module tb_rr_lock_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] done;
   logic [3:0] grant;
   logic [1:0] grant_id;
   logic       busy;
   logic       timeout;

   int n_checks;
   int n_errors;

   rr_lock_arbiter #(.MAX_HOLD(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .done     (done),
      .grant    (grant),
      .grant_id (grant_id),
      .busy     (busy),
      .timeout  (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [3:0] eg, input logic [1:0] eid, input logic eto);
      logic [7:0] exp_v;
      logic [7:0] obs_v;
      exp_v = {eg, eid, |eg, eto};
      obs_v = {grant, grant_id, busy, timeout};
      n_checks++;
      assert (obs_v === exp_v) else begin
         n_errors++;
         $error("FAIL %s: observed grant/id/busy/timeout=%b expected %b", tag, obs_v, exp_v);
      end
   endtask

   initial begin
      logic [1:0] id_v;
      logic [3:0] g_v;
      n_checks = 0;
      n_errors = 0;
      rst  = 1'b1;
      req  = 4'd0;
      done = 4'd0;
      #1;
      check("reset_state", 4'b0000, 2'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      check("idle_no_req", 4'b0000, 2'd0, 1'b0);

      // Single requester 0 after reset.
      req = 4'b0001;
      tick();
      check("req0_grant", 4'b0001, 2'd0, 1'b0);
      done = 4'b1110;
      tick();
      check("req0_ignore_other_done", 4'b0001, 2'd0, 1'b0);
      done = 4'b0000;
      req  = 4'b0000;
      tick();
      check("req0_drop_release", 4'b0000, 2'd0, 1'b0);

      // Fresh reset, then full rotation with done on each grant's second cycle.
      #2 rst = 1'b1;
      #1 check("reset_pulse", 4'b0000, 2'd0, 1'b0);
      #2 rst = 1'b0;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         id_v = 2'(k % 4);
         g_v  = 4'b0001 << id_v;
         tick();
         check("rot_cycle1", g_v, id_v, 1'b0);
         tick();
         check("rot_cycle2", g_v, id_v, 1'b0);
         done = g_v;
         tick();
         check("rot_gap", 4'b0000, 2'd0, 1'b0);
         done = 4'b0000;
      end
      req = 4'b0000;
      tick();
      check("rot_idle", 4'b0000, 2'd0, 1'b0);

      // Hold limit: 4 grant cycles, timeout pulse, regrant.
      req = 4'b0100;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("hold_grant", 4'b0100, 2'd2, 1'b0);
      end
      tick();
      check("hold_timeout", 4'b0000, 2'd0, 1'b1);
      tick();
      check("hold_regrant", 4'b0100, 2'd2, 1'b0);
      req = 4'b0000;
      tick();
      check("hold_drop", 4'b0000, 2'd0, 1'b0);

      // Owner 1 drops its request in its third cycle; id 3 precedes 0.
      req = 4'b0010;
      tick();
      check("drop_grant1", 4'b0010, 2'd1, 1'b0);
      req = 4'b1011;
      tick();
      check("drop_nonowner_req", 4'b0010, 2'd1, 1'b0);
      tick();
      check("drop_cycle3", 4'b0010, 2'd1, 1'b0);
      req = 4'b1001;
      tick();
      check("drop_release", 4'b0000, 2'd0, 1'b0);
      tick();
      check("drop_next_is_3", 4'b1000, 2'd3, 1'b0);

      // Owner 2 ignores foreign done bits; done coincides with hold limit.
      req = 4'b0100;
      tick();
      check("lim_release3", 4'b0000, 2'd0, 1'b0);
      tick();
      check("lim_grant2", 4'b0100, 2'd2, 1'b0);
      done = 4'b1011;
      tick();
      check("lim_foreign_done_a", 4'b0100, 2'd2, 1'b0);
      tick();
      check("lim_foreign_done_b", 4'b0100, 2'd2, 1'b0);
      tick();
      check("lim_last_cycle", 4'b0100, 2'd2, 1'b0);
      done = 4'b0100;
      tick();
      check("lim_done_no_timeout", 4'b0000, 2'd0, 1'b0);
      done = 4'b0000;
      req  = 4'b0000;
      tick();
      check("lim_idle", 4'b0000, 2'd0, 1'b0);

      // Asynchronous reset mid-grant, then priority restored to requester 0 side.
      req = 4'b0010;
      tick();
      check("rst_grant1", 4'b0010, 2'd1, 1'b0);
      #2 rst = 1'b1;
      #1 check("rst_async_drop", 4'b0000, 2'd0, 1'b0);
      req = 4'b1010;
      #2 rst = 1'b0;
      tick();
      check("rst_prio_restored", 4'b0010, 2'd1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
